// File: rtl/mux_arb_nxw.sv
// mux_arb_nxw: registered N-channel multiplexer with valid/ready handshake.
// The source is picked at runtime: mode=0 uses the external select, and
// mode=1 uses round-robin arbitration. A single output register stage sits
// between the producers and one consumer. Throughput is one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index in mode 0; values >= NCH grant nothing
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (one-hot or zero)
//   out_data   registered data word
//   out_chan   index of the channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word
module mux_arb_nxw #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

  logic             load_en;
  logic             gnt_any;
  logic [SELW-1:0]  gnt_idx;
  logic [NCH-1:0]   gnt;
  logic [WIDTH-1:0] gnt_data;
  logic [SELW-1:0]  ptr_nxt;

  // The output register can take a word when it is empty or drained this cycle.
  assign load_en = !out_valid_q | out_ready;

  // Candidate selection. This depends only on mode, sel, in_valid and rr_ptr.
  // The data word never feeds the grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      for (int i = 0; i < NCH; i++)
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(i);
        end
    end else begin
      // Scan in priority order rr_ptr, rr_ptr+1, ... with wrap-around.
      // The first valid channel found wins.
      for (int k = 0; k < NCH; k++)
        for (int i = 0; i < NCH; i++)
          if (!gnt_any && i == (int'(rr_ptr_q) + k) % NCH && in_valid[i]) begin
            gnt_any = 1'b1;
            gnt_idx = SELW'(i);
          end
    end
  end

  // Decode the winning index into a one-hot grant, its data and the next pointer.
  always_comb begin
    gnt      = '0;
    gnt_data = '0;
    ptr_nxt  = rr_ptr_q;
    for (int i = 0; i < NCH; i++)
      if (gnt_any && gnt_idx == SELW'(i)) begin
        gnt[i]   = 1'b1;
        gnt_data = in_data[i*WIDTH +: WIDTH];
        ptr_nxt  = SELW'((i + 1) % NCH);
      end
  end

  assign in_ready = load_en ? gnt : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      // Drain without refill clears valid. Data and chan keep their last word.
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = gnt_data;
        out_chan_d = gnt_idx;
        if (mode) rr_ptr_d = ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_nxw.sv
module tb_mux_arb_nxw;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  dat [4];
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid, out_ready;

  // second instance: NCH=3, WIDTH=16
  logic        mode3;
  logic [1:0]  sel3;
  logic [47:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [15:0] out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3, out_ready3;

  always #5 clk = ~clk;

  assign in_data  = {dat[3], dat[2], dat[1], dat[0]};
  assign in_data3 = {16'hA002, 16'hA001, 16'hA000};

  mux_arb_nxw #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready));

  mux_arb_nxw #(.WIDTH(16), .NCH(3), .SELW(2)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3));

  typedef struct { logic [7:0] d; logic [1:0] c; } exp_t;
  exp_t sb[$];
  int   m_ptr;
  int   n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration for the 4-channel instance. Returns -1 for no grant.
  function automatic int mgrant();
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  // One clock with inputs already applied at the falling edge. Checks ready and
  // valid, pops the scoreboard on an output handshake, and pushes on input transfer.
  task automatic step();
    int g;
    bit le;
    logic [3:0] er;
    exp_t e;
    #1;
    g  = mgrant();
    le = (sb.size() == 0) || out_ready;
    er = (le && g >= 0) ? 4'(1 << g) : 4'b0;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, sb.size() != 0);
    if (out_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_data", out_data, e.d);
      chk("sb_chan", out_chan, e.c);
    end
    @(posedge clk); #1;
    if (le && g >= 0) begin
      e.d = dat[g];
      e.c = g[1:0];
      sb.push_back(e);
      if (mode) m_ptr = (g + 1) % 4;
    end
    @(negedge clk);
  endtask

  int rr_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [2:0]  n3_rdy  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0]  n3_chan [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

  initial begin
    n_cmp = 0; n_err = 0; m_ptr = 0;
    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    dat[0] = 8'h10; dat[1] = 8'h11; dat[2] = 8'h12; dat[3] = 8'h13;
    mode3 = 1'b0; sel3 = '0; in_valid3 = '0; out_ready3 = 1'b0;
    #1;
    chk("rst0_vld", out_valid, 1'b0);
    chk("rst0_data", out_data, 8'h00);
    chk("rst0_chan", out_chan, 2'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Load 0xA5, hold it under stall, then reset asynchronously.
    dat[0] = 8'hA5; mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b0;
    step();
    in_valid = 4'b0000;
    step();
    chk("pre_rst_data", out_data, 8'hA5);
    #2 reset = 1'b1;
    #1;
    chk("arst_vld", out_valid, 1'b0);
    chk("arst_data", out_data, 8'h00);
    chk("arst_chan", out_chan, 2'd0);
    sb.delete(); m_ptr = 0;
    @(negedge clk);
    reset = 1'b0;
    dat[0] = 8'h10;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("rr_first", in_ready, 4'b0001);
    in_valid = 4'b0000;

    // Fixed select
    @(negedge clk);
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; dat[2] = 8'h3C; out_ready = 1'b1;
    #1 chk("fix_rdy", in_ready, 4'b0100);
    step();
    chk("fix_data", out_data, 8'h3C);
    chk("fix_chan", out_chan, 2'd2);
    sel = 2'd3;
    #1 chk("fix_nogrant", in_ready, 4'b0000);
    step();
    chk("fix_drop", out_valid, 1'b0);
    chk("fix_hold", out_data, 8'h3C);
    dat[2] = 8'h12;

    // Round-robin: all valid, back-to-back
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_seq", out_chan, rr_seq[k]);
      chk("rr_vld", out_valid, 1'b1);
    end

    // Skip and wrap: move ptr to 3, then only channels 0 and 2 valid
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0101;
    #1 chk("wrap_rdy", in_ready, 4'b0001);
    step();
    chk("wrap_chan", out_chan, 2'd0);
    #1 chk("skip_rdy", in_ready, 4'b0100);
    step();
    chk("skip_chan", out_chan, 2'd2);

    // Backpressure: ch3 loads, then 3 stalled cycles, then drain+fill together
    in_valid = 4'b1111;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_rdy0", in_ready, 4'b0000);
      step();
      chk("bp_data", out_data, 8'h13);
      chk("bp_chan", out_chan, 2'd3);
      chk("bp_vld", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", in_ready, 4'b0001);
    step();
    chk("bp_refill_data", out_data, 8'h10);
    chk("bp_refill_vld", out_valid, 1'b1);
    in_valid = 4'b0000;
    step();
    step();

    // NCH=3 instance: out-of-range select, then round-robin wrap 2 -> 0
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1 chk("n3_nogrant", in_ready3, 3'b000);
    @(posedge clk); #1;
    chk("n3_novld", out_valid3, 1'b0);
    @(negedge clk);
    mode3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("n3_rdy", in_ready3, n3_rdy[k]);
      @(posedge clk); #1;
      chk("n3_chan", out_chan3, n3_chan[k]);
      chk("n3_data", out_data3, 16'hA000 + 16'(n3_chan[k]));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_nxw.md
Name: mux_arb_nxw

Overview:
- Parametrised, registered N-channel multiplexer. Successor to the 4:1 combinational select mux.
- Each input channel carries WIDTH-bit data with a valid/ready handshake.
- A runtime mode picks the source. Mode 0 uses an externally driven select. Mode 1 uses round-robin arbitration.
- Output is a single registered stage with valid/ready. It sits between multiple producers and one consumer in the datapath.

Parameters:
- WIDTH, 8, data bits per channel
- NCH, 4, number of input channels (2..16)
- SELW, 2, select/index width; must equal ceil(log2(NCH))

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mode  input  1  0 = fixed select via sel; 1 = round-robin
- sel  input  SELW  channel index used when mode=0; values >= NCH select nothing
- in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready, one-hot or zero
- out_data  output  WIDTH  registered data
- out_chan  output  SELW  index of the channel that produced out_data
- out_valid  output  1  output holds a word
- out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (asynchronous, immediate) clears: out_valid=0, out_data=0, out_chan=0, rr_ptr=0. in_ready is then 0 only while an accept is impossible (see load_en).
- load_en = !out_valid | out_ready. The output stage is empty or is being drained this cycle.
- Candidate selection is combinational and yields at most one grant.
  - mode=0: grant channel sel if sel<NCH and in_valid[sel]=1; otherwise no grant.
  - mode=1: scan channels starting at rr_ptr, upward, wrapping NCH-1 -> 0. Grant the first channel with valid=1; no grant if all are 0.
- in_ready[i] = load_en & grant[i]. in_ready depends on in_valid and sel, but never on data.
- Transfer on input i occurs when in_valid[i] & in_ready[i] at the rising edge. Then:
  - out_data <= channel i data
  - out_chan <= i
  - out_valid <= 1
  - in mode 1 only: rr_ptr <= (i+1) mod NCH
- Drain without refill: if out_valid & out_ready and there is no grant, out_valid <= 0. out_data and out_chan hold their values.
- Stall: if out_valid & !out_ready, the output is held stable and all in_ready=0.
- Simultaneous drain and fill in the same cycle: the new word loads and out_valid stays 1. Full throughput is one word per cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Mode 0 does not change rr_ptr. Switching mode takes effect in the same cycle, with no flush; a word already in the output register is unaffected.
- Round-robin fairness: with all channels valid and out_ready=1, the grant order is ptr, ptr+1, … wrapping. Each channel is served once every NCH cycles.
- Wrap-around: a grant to channel NCH-1 sets rr_ptr=0.
- Reset asserted mid-transfer: the output word is discarded and out_valid=0 immediately. After deassertion, arbitration restarts at channel 0.
- No combinational path from out_ready to out_data. There is a combinational path from out_ready to in_ready.

Test Plan:
- Reset: assert reset with out_valid=1 and out_data=0xA5. Required: out_valid=0, out_data=0, out_chan=0 at once, before any clock edge. After release, mode=1 with all valid grants channel 0 first.
- Fixed select: mode=0, sel=2, in_valid=4'b0100, ch2=0x3C, out_ready=1. Required: in_ready=4'b0100; next cycle out_data=0x3C, out_chan=2. Then set sel=3 with in_valid[3]=0. Required: in_ready=0, and out_valid drops the next cycle.
- Round-robin: mode=1, all channels valid, data ch0..3 = 0x10,0x11,0x12,0x13, out_ready=1 for 8 cycles. Required: out_chan sequence 0,1,2,3,0,1,2,3, back-to-back with out_valid=1 on every cycle.
- Skip and wrap: mode=1, rr_ptr=3, in_valid=4'b0101. Required: channel 0 granted (3 invalid, wrap), then rr_ptr=1, then channel 2 granted.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with all inputs valid. Required: in_ready=0 and out_data/out_chan stable throughout. When out_ready=1, the drain and the next load happen in the same cycle.
- Parameter sweep: NCH=3, SELW=2, WIDTH=16, mode=0, sel=3. Required: no grant and in_ready=0. In mode 1 the wrap goes 2 -> 0.
